// File: rtl/frame_scan_ctrl.sv
// frame_scan_ctrl: sequences one frame readout in raster order, one ADC conversion per pixel tick.
// Define FRAME_SCAN_ROW_BLANK_EN to skip BlankTicks ticks after every row except the last.
module frame_scan_ctrl #(
   parameter int Cols       = 80,
   parameter int Rows       = 60,
   parameter int ColW       = 7,
   parameter int RowW       = 6,
   parameter int BlankTicks = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            tick_i,
   input  logic            adc_done_i,
   output logic            adc_start_o,
   output logic            pix_valid_o,
   output logic [ColW-1:0] col_o,
   output logic [RowW-1:0] row_o,
   output logic            busy_o,
   output logic            frame_done_o,
   output logic            overrun_o
);

   if (Cols < 2 || Rows < 2 || BlankTicks < 1 ||
       (64'd1 << ColW) < 64'(Cols) || (64'd1 << RowW) < 64'(Rows)) begin : g_bad_params
      $error("frame_scan_ctrl: illegal parameter combination");
   end

   localparam logic [ColW-1:0] ColLast = ColW'(Cols - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(Rows - 1);

`ifdef FRAME_SCAN_ROW_BLANK_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_TICK,
      ST_CONV,
      ST_NEXT,
      ST_BLANK
   } state_t;

   localparam int              BlankW    = $clog2(BlankTicks + 1);
   localparam logic [BlankW-1:0] BlankLast = BlankW'(BlankTicks - 1);

   logic [BlankW-1:0] blank_cnt;
`else
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_TICK,
      ST_CONV,
      ST_NEXT
   } state_t;
`endif

   state_t state;

   // NOTE: every register here is updated with <= so all branches see the pre-edge values of
   // row/col/state; a blocking update would let the NEXT address test see a half-advanced address.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= ST_IDLE;
         adc_start_o  <= 1'b0;
         pix_valid_o  <= 1'b0;
         col_o        <= '0;
         row_o        <= '0;
         busy_o       <= 1'b0;
         frame_done_o <= 1'b0;
         overrun_o    <= 1'b0;
`ifdef FRAME_SCAN_ROW_BLANK_EN
         blank_cnt    <= '0;
`endif
      end else begin
         // NOTE: pulse outputs default low each cycle so a pulse lasts exactly one clock
         // without needing a clear in every state branch.
         adc_start_o  <= 1'b0;
         pix_valid_o  <= 1'b0;
         frame_done_o <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  col_o     <= '0;
                  row_o     <= '0;
                  overrun_o <= 1'b0;
                  busy_o    <= 1'b1;
                  state     <= ST_WAIT_TICK;
               end
            end

            ST_WAIT_TICK: begin
               if (tick_i) begin
                  adc_start_o <= 1'b1;
                  state       <= ST_CONV;
               end
            end

            ST_CONV: begin
               // A tick here means the pixel clock outran the ADC; it is flagged, not queued.
               if (tick_i) begin
                  overrun_o <= 1'b1;
               end
               if (adc_done_i) begin
                  pix_valid_o <= 1'b1;
                  state       <= ST_NEXT;
               end
            end

            ST_NEXT: begin
               if (col_o != ColLast) begin
                  col_o <= col_o + ColW'(1);
                  state <= ST_WAIT_TICK;
               end else if (row_o != RowLast) begin
                  col_o <= '0;
                  row_o <= row_o + RowW'(1);
`ifdef FRAME_SCAN_ROW_BLANK_EN
                  blank_cnt <= '0;
                  state     <= ST_BLANK;
`else
                  state     <= ST_WAIT_TICK;
`endif
               end else begin
                  col_o        <= '0;
                  row_o        <= '0;
                  frame_done_o <= 1'b1;
                  busy_o       <= 1'b0;
                  state        <= ST_IDLE;
               end
            end

`ifdef FRAME_SCAN_ROW_BLANK_EN
            ST_BLANK: begin
               if (tick_i) begin
                  if (blank_cnt == BlankLast) begin
                     blank_cnt <= '0;
                     state     <= ST_WAIT_TICK;
                  end else begin
                     blank_cnt <= blank_cnt + BlankW'(1);
                  end
               end
            end
`endif

            default: begin
               busy_o <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Self-checking bench for frame_scan_ctrl (Cols=4, Rows=2): pixel-index reference model plus directed checks.
// Honours FRAME_SCAN_ROW_BLANK_EN with BlankTicks=2 when the macro is defined.
module tb_frame_scan_ctrl;
   localparam int COLS  = 4;
   localparam int ROWS  = 2;
   localparam int COL_W = 2;
   localparam int ROW_W = 1;
   localparam int BLANK = 2;
   localparam int NPIX  = COLS * ROWS;
`ifdef FRAME_SCAN_ROW_BLANK_EN
   localparam int BLANK_EFF = BLANK;
`else
   localparam int BLANK_EFF = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic tick = 1'b0;
   logic done = 1'b0;

   logic             adc_start_o;
   logic             pix_valid_o;
   logic [COL_W-1:0] col_o;
   logic [ROW_W-1:0] row_o;
   logic             busy_o;
   logic             frame_done_o;
   logic             overrun_o;

   int   checks   = 0;
   int   failures = 0;
   bit   cmp_en   = 1'b0;
   int   fd_cnt   = 0;
   logic [7:0] seq_q[$];
   logic [7:0] exp_seq[NPIX] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13};

   always #5 clk = ~clk;

   frame_scan_ctrl #(
      .Cols(COLS), .Rows(ROWS), .ColW(COL_W), .RowW(ROW_W), .BlankTicks(BLANK)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .tick_i(tick), .adc_done_i(done),
      .adc_start_o(adc_start_o), .pix_valid_o(pix_valid_o), .col_o(col_o), .row_o(row_o),
      .busy_o(busy_o), .frame_done_o(frame_done_o), .overrun_o(overrun_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame progress as a linear pixel index plus a few activity flags.
   bit m_busy, m_conv, m_adv, m_adc, m_pv, m_fd, m_ovr;
   int m_blank, m_pix;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_conv = 0; m_adv = 0; m_adc = 0; m_pv = 0; m_fd = 0; m_ovr = 0;
         m_blank = 0; m_pix = 0;
      end else begin
         m_adc = 0; m_pv = 0; m_fd = 0;
         if (!m_busy) begin
            if (start) begin
               m_busy = 1; m_pix = 0; m_ovr = 0; m_conv = 0; m_adv = 0; m_blank = 0;
            end
         end else if (m_adv) begin
            m_adv = 0;
            if (m_pix == NPIX - 1) begin
               m_busy = 0; m_fd = 1; m_pix = 0;
            end else begin
               m_pix++;
               if (m_pix % COLS == 0) m_blank = BLANK_EFF;
            end
         end else if (m_conv) begin
            if (tick) m_ovr = 1;
            if (done) begin
               m_conv = 0; m_adv = 1; m_pv = 1;
            end
         end else if (m_blank > 0) begin
            if (tick) m_blank--;
         end else if (tick) begin
            m_adc = 1; m_conv = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cmp_adc_start", adc_start_o, m_adc);
         check("cmp_pix_valid", pix_valid_o, m_pv);
         check("cmp_row", 32'(row_o), m_pix / COLS);
         check("cmp_col", 32'(col_o), m_pix % COLS);
         check("cmp_busy", busy_o, m_busy);
         check("cmp_frame_done", frame_done_o, m_fd);
         check("cmp_overrun", overrun_o, m_ovr);
         if (pix_valid_o === 1'b1) seq_q.push_back({4'(row_o), 4'(col_o)});
         if (frame_done_o === 1'b1) fd_cnt++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_adc_start"}, adc_start_o, 0);
      check({tag, "_pix_valid"}, pix_valid_o, 0);
      check({tag, "_col"}, 32'(col_o), 0);
      check({tag, "_row"}, 32'(row_o), 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_frame_done"}, frame_done_o, 0);
      check({tag, "_overrun"}, overrun_o, 0);
   endtask

   task automatic check_seq(input string tag);
      check({tag, "_pix_count"}, seq_q.size(), NPIX);
      check({tag, "_frame_done_count"}, fd_cnt, 1);
      for (int i = 0; i < NPIX && i < seq_q.size(); i++) begin
         check({tag, "_addr"}, seq_q[i], exp_seq[i]);
      end
   endtask

   // One pixel: tick, ADC done 3 cycles after adc_start, optional disturbances.
   // xs: start mid-frame, ed: done while waiting for tick, ovr: tick during conversion,
   // tnx: tick during the address-advance cycle, abort: reset while converting.
   task automatic do_pixel(input int r, input int c, input bit xs, input bit ed, input bit ovr,
                           input bit tnx, input bit abort, input bit last);
`ifdef FRAME_SCAN_ROW_BLANK_EN
      if (c == 0 && r > 0) begin
         for (int k = 0; k < BLANK; k++) begin
            tick = 1'b1; cyc(1); tick = 1'b0;
            check("blank_no_adc_start", adc_start_o, 0);
            cyc(3);
         end
      end
`endif
      cyc(2);
      if (ed) begin done = 1'b1; cyc(1); done = 1'b0; end else cyc(1);
      check("wait_no_pix_valid", pix_valid_o, 0);
      if (xs) begin start = 1'b1; cyc(1); start = 1'b0; end else cyc(1);
      tick = 1'b1; cyc(1); tick = 1'b0;
      check("adc_start_t1", adc_start_o, 1);
      cyc(1);
      check("adc_start_t2", adc_start_o, 0);
      if (abort) begin
         #1 rst = 1'b1;
         #1 check_all_zero("rst_mid");
         return;
      end
      if (ovr) tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      if (ovr) check("overrun_set", overrun_o, 1);
      check("pix_valid_early", pix_valid_o, 0);
      done = 1'b1; cyc(1); done = 1'b0;
      check("pix_valid_u1", pix_valid_o, 1);
      check("pix_row", 32'(row_o), r);
      check("pix_col", 32'(col_o), c);
      if (tnx) tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      check("pix_valid_u2", pix_valid_o, 0);
      check("frame_done_pulse", frame_done_o, last);
      check("busy_after_pixel", busy_o, !last);
      cyc(2);
   endtask

   initial begin
      // Reset held with random inputs.
      repeat (5) begin
         @(negedge clk);
         cmp_en = 1'b1;
         start = 1'($urandom_range(0, 1));
         tick  = 1'($urandom_range(0, 1));
         done  = 1'($urandom_range(0, 1));
         check_all_zero("rst_hold");
      end
      @(negedge clk);
      start = 1'b0; tick = 1'b0; done = 1'b0; rst = 1'b0;
      cyc(3);
      check("idle_busy", busy_o, 0);

      // Frame 1 with disturbances: mid-frame start, early done, tick in NEXT, overrun.
      start = 1'b1; cyc(1); start = 1'b0;
      check("start_busy", busy_o, 1);
      check("start_overrun", overrun_o, 0);
      for (int p = 0; p < NPIX; p++) begin
         do_pixel(p / COLS, p % COLS, p == 1, p == 2, p == 5, p == 3 || p == 7, 1'b0, p == NPIX - 1);
      end
      check("overrun_sticky", overrun_o, 1);
      cyc(3);
      check("overrun_idle", overrun_o, 1);
      check_seq("frame1");

      // Frame 2: level start clears overrun, then reset during pixel (1,1).
      seq_q.delete(); fd_cnt = 0;
      start = 1'b1; cyc(1);
      check("restart_overrun_clr", overrun_o, 0);
      cyc(2); start = 1'b0;
      for (int p = 0; p <= 5; p++) begin
         do_pixel(p / COLS, p % COLS, 1'b0, 1'b0, 1'b0, 1'b0, p == 5, 1'b0);
      end
      cyc(1);
      done = 1'b1; cyc(1); done = 1'b0;
      rst = 1'b0;
      cyc(1);
      done = 1'b1; cyc(1); done = 1'b0;
      cyc(2);
      check("post_rst_pix_valid", pix_valid_o, 0);
      check("post_rst_busy", busy_o, 0);

      // Frame 3: clean frame must restart at (0,0).
      seq_q.delete(); fd_cnt = 0;
      start = 1'b1; cyc(1); start = 1'b0;
      for (int p = 0; p < NPIX; p++) begin
         do_pixel(p / COLS, p % COLS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, p == NPIX - 1);
      end
      cyc(3);
      check_seq("frame3");
      check("final_busy", busy_o, 0);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
